// File: rtl/dap_usb_pkg.sv
// Shared constants and types for the DAP USB bulk transport.
package dap_usb_pkg;

    localparam int         USB_LEN_W   = 12;
    localparam int         DAP_MAX_PKT = 512;
    localparam int         DAP_EP_W    = 4;
    localparam logic [3:0] DAP_EP_IN   = 4'd2;

    // Progress of one IN transaction on the DAP endpoint.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ACTIVE,
        TX_ACKED
    } tx_state_e;

endpackage

// File: rtl/dap_usb_len_fifo.sv
// Synchronous FIFO of committed USB packet lengths; head is the packet
// currently offered to the controller.
module dap_usb_len_fifo
    import dap_usb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  logic [USB_LEN_W-1:0]    din,
    output logic [USB_LEN_W-1:0]    head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = DEPTH[AW:0];

    logic [USB_LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CAP);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The queue is small and its head is a visible output, so it is cleared
    // on reset to keep usb_txdat_len at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dap_usb_transmitter.sv
// DAP response bytes (AXI-Stream) -> byte FIFO -> USB IN packets with retransmit.
// Optional zero-length packet after a full-size final packet: define DAP_TX_ZLP_EN.
module dap_usb_transmitter
    import dap_usb_pkg::*;
#(
    parameter logic [3:0] P_ENDPOINT = DAP_EP_IN,
    parameter int         FIFO_DEPTH = 4096,
    parameter int         MAX_PKT    = DAP_MAX_PKT,
    parameter int         LEN_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DAP_EP_W-1:0]    usb_endpt,
    input  logic                   usb_txact,
    input  logic                   usb_txpop,
    input  logic                   usb_txack,
    output logic [7:0]             usb_txdat,
    output logic [USB_LEN_W-1:0]   usb_txdat_len,
    output logic                   usb_txcork,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    input  logic [7:0]             axis_tdata,
    input  logic                   axis_tvalid,
    input  logic                   axis_tlast,
    output logic                   axis_tready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(LEN_DEPTH);
    localparam logic [AW:0]          FIFO_CAP = FIFO_DEPTH[AW:0];
    localparam logic [USB_LEN_W-1:0] MAX_LEN  = MAX_PKT[USB_LEN_W-1:0];

    typedef logic [AW:0] ptr_t;

    logic [7:0]           ram [FIFO_DEPTH];
    ptr_t                 wptr, rptr, rptr_tmp, rptr_tmp_nxt;
    logic [USB_LEN_W-1:0] cur_len, cur_len_inc, push_len, head_len;
    logic [LW:0]          len_count;
    logic                 ep_sel, act, ack, pop_ok, start, rewind;
    logic                 accept, commit, len_push, len_full, len_empty, data_full;
    tx_state_e            state, state_nxt;

    assign ep_sel = (usb_endpt == P_ENDPOINT);
    assign act    = usb_txact && ep_sel;
    assign ack    = usb_txack && ep_sel;

    // ---------------- write side ----------------
    assign data_full   = ((wptr - rptr) == FIFO_CAP);
    assign accept      = axis_tvalid && axis_tready;
    assign cur_len_inc = cur_len + 1'b1;
    assign commit      = accept && (axis_tlast || (cur_len_inc == MAX_LEN));

`ifdef DAP_TX_ZLP_EN
    localparam int          LEN_ZLP_LIM_I = LEN_DEPTH - 1;
    localparam logic [LW:0] LEN_ZLP_LIM   = LEN_ZLP_LIM_I[LW:0];

    // The zero-length entry goes in the cycle after its full-size packet;
    // the writer is stalled meanwhile so the two pushes never collide.
    logic zlp_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) zlp_pend <= 1'b0;
        else         zlp_pend <= commit && axis_tlast && (cur_len_inc == MAX_LEN);
    end

    assign len_push    = commit || zlp_pend;
    assign push_len    = zlp_pend ? '0 : cur_len_inc;
    assign axis_tready = !data_full && !zlp_pend && (len_count < LEN_ZLP_LIM);
`else
    localparam logic [LW:0] LEN_CAP = LEN_DEPTH[LW:0];

    assign len_push    = commit;
    assign push_len    = cur_len_inc;
    assign axis_tready = !data_full && (len_count < LEN_CAP);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr    <= '0;
            cur_len <= '0;
        end else if (accept) begin
            wptr    <= wptr + 1'b1;
            cur_len <= commit ? '0 : cur_len_inc;
        end
    end

    // NOTE: the byte RAM has no reset; contents are only ever read behind
    // committed pointers, so resetting it would only block RAM inference.
    always_ff @(posedge clk) begin
        if (accept) ram[wptr[AW-1:0]] <= axis_tdata;
    end

    dap_usb_len_fifo #(
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (len_push),
        .pop    (ack),
        .din    (push_len),
        .head   (head_len),
        .full   (len_full),
        .empty  (len_empty),
        .count  (len_count)
    );

    // ---------------- read side ----------------
    assign usb_txdat_len = head_len;
    assign usb_txcork    = len_empty;
    assign pop_ok        = usb_txpop && ep_sel && !len_empty &&
                           ((rptr_tmp - rptr) < ptr_t'(head_len));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        rewind    = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (act) begin
                    state_nxt = TX_ACTIVE;
                    start     = 1'b1;
                end
            end
            TX_ACTIVE: begin
                if (ack) begin
                    state_nxt = act ? TX_ACKED : TX_IDLE;
                end else if (!act) begin
                    state_nxt = TX_IDLE;
                    rewind    = 1'b1;
                end
            end
            TX_ACKED: begin
                if (!act) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // The registered read of the next read address gives the 1-cycle prefetch.
    always_comb begin
        rptr_tmp_nxt = rptr_tmp;
        if (start || rewind) rptr_tmp_nxt = rptr;
        else if (pop_ok)     rptr_tmp_nxt = rptr_tmp + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= TX_IDLE;
            rptr      <= '0;
            rptr_tmp  <= '0;
            usb_txdat <= '0;
        end else begin
            state     <= state_nxt;
            rptr_tmp  <= rptr_tmp_nxt;
            usb_txdat <= ram[rptr_tmp_nxt[AW-1:0]];
            if (ack && !len_empty) rptr <= rptr_tmp;
        end
    end

    // ---------------- status ----------------
    assign fifo_full  = data_full || len_full;
    assign fifo_empty = (wptr == rptr) && len_empty;

endmodule

// File: tb/tb_dap_usb_transmitter.sv
// Scoreboard bench for dap_usb_transmitter: packet-level model plus an
// independent monitor on the USB side.
module tb_dap_usb_transmitter;

    localparam int         MAX_PKT    = 512;
    localparam int         FIFO_DEPTH = 4096;
    localparam int         LEN_DEPTH  = 16;
    localparam logic [3:0] EP         = 4'd2;
`ifdef DAP_TX_ZLP_EN
    localparam bit ZLP     = 1'b1;
    localparam int N_CHUNK = 15;
`else
    localparam bit ZLP     = 1'b0;
    localparam int N_CHUNK = 16;
`endif

    logic        clk, resetn;
    logic [3:0]  usb_endpt;
    logic        usb_txact, usb_txpop, usb_txack;
    logic [7:0]  usb_txdat;
    logic [11:0] usb_txdat_len;
    logic        usb_txcork, fifo_full, fifo_empty;
    logic [7:0]  axis_tdata;
    logic        axis_tvalid, axis_tlast, axis_tready;

    dap_usb_transmitter #(
        .P_ENDPOINT (EP),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_PKT    (MAX_PKT),
        .LEN_DEPTH  (LEN_DEPTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .usb_endpt     (usb_endpt),
        .usb_txact     (usb_txact),
        .usb_txpop     (usb_txpop),
        .usb_txack     (usb_txack),
        .usb_txdat     (usb_txdat),
        .usb_txdat_len (usb_txdat_len),
        .usb_txcork    (usb_txcork),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .axis_tdata    (axis_tdata),
        .axis_tvalid   (axis_tvalid),
        .axis_tlast    (axis_tlast),
        .axis_tready   (axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: committed packets as a flat byte stream plus a length list.
    byte unsigned exp_bytes[$];
    int           exp_lens[$];
    byte unsigned cur_pkt[$];

    int   mon_idx;
    logic mon_act, act_prev;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void model_accept(input byte unsigned d, input bit last);
        int n;
        cur_pkt.push_back(d);
        n = cur_pkt.size();
        if (last || n == MAX_PKT) begin
            foreach (cur_pkt[i]) exp_bytes.push_back(cur_pkt[i]);
            exp_lens.push_back(n);
            if (ZLP && last && n == MAX_PKT) exp_lens.push_back(0);
            cur_pkt.delete();
        end
    endfunction

    // Monitor: compares everything the DUT presents on the USB side.
    always @(negedge clk) begin
        mon_act = usb_txact && (usb_endpt == EP);
        if (!resetn) begin
            mon_idx  = 0;
            act_prev = 1'b0;
        end else begin
            if (mon_act && !act_prev) begin
                mon_idx = 0;
                if (exp_lens.size() == 0) begin
                    check("cork_idle", usb_txcork, 1);
                end else begin
                    check("cork_ready", usb_txcork, 0);
                    check("pkt_len", usb_txdat_len, exp_lens[0]);
                end
            end
            if (mon_act && usb_txpop && exp_lens.size() > 0 && mon_idx < exp_lens[0]) begin
                check("pop_byte", usb_txdat, exp_bytes[mon_idx]);
                mon_idx++;
            end
            if (usb_txack && usb_endpt == EP && exp_lens.size() > 0) begin
                check("ack_count", mon_idx, exp_lens[0]);
                for (int i = 0; i < exp_lens[0]; i++) void'(exp_bytes.pop_front());
                void'(exp_lens.pop_front());
                mon_idx = 0;
            end
            if (!mon_act) mon_idx = 0;
            act_prev = mon_act;
        end
    end

    // All driver tasks start and end at posedge + 1.
    task automatic send(input logic [7:0] d, input bit last);
        int n = 0;
        axis_tdata  = d;
        axis_tlast  = last;
        axis_tvalid = 1'b1;
        @(negedge clk);
        while (!axis_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!axis_tready) begin
            check("tready_timeout", 0, 1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            model_accept(d, last);
        end
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
    endtask

    task automatic send_resp(input int n);
        for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)), i == n - 1);
    endtask

    task automatic in_open(input logic [3:0] ep);
        usb_endpt = ep;
        usb_txact = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic in_pops(input int n);
        if (n > 0) begin
            usb_txpop = 1'b1;
            repeat (n) @(posedge clk);
            #1;
            usb_txpop = 1'b0;
        end
    endtask

    task automatic in_ack();
        usb_txack = 1'b1;
        @(posedge clk); #1;
        usb_txack = 1'b0;
    endtask

    task automatic in_close();
        usb_txact = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        usb_endpt = 4'd0;
    endtask

    task automatic transact(input int n, input bit do_ack);
        in_open(EP);
        in_pops(n);
        if (do_ack) in_ack();
        in_close();
    endtask

    task automatic drain(input bit naks, output int npkt);
        int n;
        npkt = 0;
        for (int g = 0; g < 64 && exp_lens.size() > 0; g++) begin
            n = exp_lens[0];
            if (naks && $urandom_range(0, 2) == 0) transact(n, 1'b0);
            transact(n, 1'b1);
            npkt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npkt;
        resetn = 1'b0;
        usb_endpt = '0; usb_txact = 1'b0; usb_txpop = 1'b0; usb_txack = 1'b0;
        axis_tdata = '0; axis_tvalid = 1'b0; axis_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txdat", usb_txdat, 0);
        check("rst_len", usb_txdat_len, 0);
        check("rst_cork", usb_txcork, 1);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_tready", axis_tready, 1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Five fixed bytes, one IN with extra pops beyond the length.
        for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
        @(negedge clk);
        check("t1_cork", usb_txcork, 0);
        check("t1_len", usb_txdat_len, 5);
        check("t1_empty", fifo_empty, 0);
        @(posedge clk); #1;
        transact(7, 1'b1);
        @(negedge clk);
        check("t1_cork_after", usb_txcork, 1);
        check("t1_empty_after", fifo_empty, 1);
        @(posedge clk); #1;

        // 600-byte response splits into 512 + 88.
        send_resp(600);
        drain(1'b0, npkt);
        check("split_pkts", npkt, 2);

        // NAK then resend, then the following packet.
        send_resp(20);
        send_resp(7);
        transact(20, 1'b0);
        transact(20, 1'b1);
        transact(7, 1'b1);
        @(negedge clk);
        check("nak_cork_after", usb_txcork, 1);
        @(posedge clk); #1;

        // IN activity on another endpoint leaves the packet untouched.
        send_resp(9);
        in_open(4'd3);
        in_pops(4);
        in_ack();
        in_close();
        @(negedge clk);
        check("other_ep_cork", usb_txcork, 0);
        check("other_ep_len", usb_txdat_len, 9);
        @(posedge clk); #1;
        drain(1'b0, npkt);

        // Full-size tlast response: zero-length follow-up only with the option.
        send_resp(MAX_PKT);
        drain(1'b0, npkt);
        check("zlp_pkts", npkt, ZLP ? 2 : 1);
        @(negedge clk);
        check("zlp_cork_after", usb_txcork, 1);
        check("zlp_empty_after", fifo_empty, 1);
        @(posedge clk); #1;

        // Fill to capacity with 256-byte chunks, then free one packet.
        for (int c = 0; c < N_CHUNK; c++) send_resp(256);
        @(negedge clk);
        check("fill_tready", axis_tready, 0);
        check("fill_full", fifo_full, ZLP ? 0 : 1);
        @(posedge clk); #1;
        in_open(EP);
        in_pops(256);
        usb_txack = 1'b1;
        @(negedge clk);
        check("tready_at_ack", axis_tready, 0);
        @(posedge clk); #1;
        usb_txack = 1'b0;
        @(negedge clk);
        check("tready_after_ack", axis_tready, 1);
        check("full_after_ack", fifo_full, 0);
        @(posedge clk); #1;
        in_close();
        drain(1'b1, npkt);

        // Random responses with random NAKs.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) send_resp($urandom_range(1, 700));
            drain(1'b1, npkt);
        end
        @(negedge clk);
        check("rand_empty", fifo_empty, 1);
        @(posedge clk); #1;

        // Reset in the middle of an IN transaction.
        send_resp(10);
        in_open(EP);
        in_pops(3);
        resetn = 1'b0;
        usb_txact = 1'b0;
        usb_txpop = 1'b0;
        usb_endpt = 4'd0;
        #1;
        check("mid_rst_txdat", usb_txdat, 0);
        check("mid_rst_len", usb_txdat_len, 0);
        check("mid_rst_cork", usb_txcork, 1);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_full", fifo_full, 0);
        check("mid_rst_tready", axis_tready, 1);
        exp_bytes.delete();
        exp_lens.delete();
        cur_pkt.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        in_open(EP);
        check("post_rst_cork", usb_txcork, 1);
        in_close();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
